wishbone_register_bank: RTL

Parametrised bank of NUM_REGS 32-bit Wishbone-slave registers at consecutive word addresses in the Caravel user window (from 0x3000_0000). It generalises the single-address register with byte-lane writes, a one-cycle ack pulse per transfer, per-register readback selection, and per-register write/read strobes. It sits between the Caravel Wishbone bus and user logic, one instance per peripheral.

---
 rtl/wishbone_register_pkg.sv | 12 +
 rtl/wishbone_register_slot.sv | 35 +++
 rtl/wishbone_register_bank.sv | 88 ++++++++
 3 files changed

// File: rtl/wishbone_register_pkg.sv
// wishbone_register_pkg: bus widths, Caravel user window base and base-address sanity check
package wishbone_register_pkg;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W = 4;
    localparam int WB_ADDR_W = 32;
    localparam int WB_STRIDE = 4;
    localparam logic [WB_ADDR_W-1:0] USER_SPACE_BASE = 32'h3000_0000;

    function automatic logic base_address_ok(input logic [WB_ADDR_W-1:0] addr);
        return (addr >= USER_SPACE_BASE) && (addr[1:0] == 2'b00);
    endfunction
endpackage

// File: rtl/wishbone_register_slot.sv
// wishbone_register_slot: one 32-bit register with byte-lane write and a write strobe
module wishbone_register_slot
    import wishbone_register_pkg::*;
#(
    parameter logic [WB_DATA_W-1:0] RESET_VALUE = '0
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wr_en_i,
    input  logic [WB_SEL_W-1:0]  sel_i,
    input  logic [WB_DATA_W-1:0] dat_i,
    output logic [WB_DATA_W-1:0] q_o,
    output logic                 wr_pulse_o
);
    logic [WB_DATA_W-1:0] reg_q, reg_d;
    logic                 wr_pulse_q;

    always_comb begin
        for (int k = 0; k < WB_SEL_W; k++)
            reg_d[8*k +: 8] = (wr_en_i && sel_i[k]) ? dat_i[8*k +: 8] : reg_q[8*k +: 8];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            reg_q      <= RESET_VALUE;
            wr_pulse_q <= 1'b0;
        end else begin
            reg_q      <= reg_d;
            wr_pulse_q <= wr_en_i;
        end
    end

    assign q_o        = reg_q;
    assign wr_pulse_o = wr_pulse_q;
endmodule

// File: rtl/wishbone_register_bank.sv
// wishbone_register_bank: NUM_REGS word registers on the Caravel Wishbone bus with
// byte-lane writes, selectable read source and per-register read/write strobes
module wishbone_register_bank
    import wishbone_register_pkg::*;
#(
    parameter logic [WB_ADDR_W-1:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int                   NUM_REGS     = 4,
    parameter logic [WB_DATA_W-1:0] RESET_VALUE  = 32'h0,
    parameter logic [NUM_REGS-1:0]  RD_LOOPBACK  = '0
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_we_i,
    input  logic [WB_SEL_W-1:0]           wbs_sel_i,
    input  logic [WB_DATA_W-1:0]          wbs_dat_i,
    input  logic [WB_ADDR_W-1:0]          wbs_adr_i,
    input  logic [WB_DATA_W*NUM_REGS-1:0] data_i,
    output logic                          wbs_ack_o,
    output logic [WB_DATA_W-1:0]          wbs_dat_o,
    output logic [WB_DATA_W*NUM_REGS-1:0] reg_q_o,
    output logic [NUM_REGS-1:0]           wr_pulse_o,
    output logic [NUM_REGS-1:0]           rd_pulse_o
);
    if (!base_address_ok(BASE_ADDRESS)) begin : g_bad_base
        $error("BASE_ADDRESS must be word aligned and inside the user window");
    end
    if (NUM_REGS < 1 || NUM_REGS > 64) begin : g_bad_num
        $error("NUM_REGS must be in 1..64");
    end

    logic [WB_ADDR_W-1:0] offset;
    logic                 hit, accept;
    logic                 ack_q, ack_d;
    logic [WB_DATA_W-1:0] dat_q, dat_d, rd_word;
    logic [NUM_REGS-1:0]  wr_en, rd_pulse_q, rd_pulse_d;

    // Unsigned wrap below the base makes offset huge, so the range test fails as well
    assign offset = wbs_adr_i - BASE_ADDRESS;
    assign hit    = wbs_cyc_i && wbs_stb_i && (wbs_adr_i >= BASE_ADDRESS)
                    && (offset < 32'(NUM_REGS * WB_STRIDE));
    assign accept = hit && !ack_q;

    always_comb begin
        rd_word    = '0;
        wr_en      = '0;
        rd_pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (offset[WB_ADDR_W-1:2] == 30'(i)) begin
                rd_word       = RD_LOOPBACK[i] ? reg_q_o[WB_DATA_W*i +: WB_DATA_W]
                                               : data_i[WB_DATA_W*i +: WB_DATA_W];
                wr_en[i]      = accept && wbs_we_i;
                rd_pulse_d[i] = accept && !wbs_we_i;
            end
        end
        ack_d = accept;
        dat_d = (accept && !wbs_we_i) ? rd_word : dat_q;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            rd_pulse_q <= '0;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            rd_pulse_q <= rd_pulse_d;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
        wishbone_register_slot #(.RESET_VALUE(RESET_VALUE)) u_slot (
            .wb_clk_i  (wb_clk_i),
            .wb_rst_i  (wb_rst_i),
            .wr_en_i   (wr_en[i]),
            .sel_i     (wbs_sel_i),
            .dat_i     (wbs_dat_i),
            .q_o       (reg_q_o[WB_DATA_W*i +: WB_DATA_W]),
            .wr_pulse_o(wr_pulse_o[i])
        );
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign rd_pulse_o = rd_pulse_q;
endmodule
